// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises ps2clk/ps2data, deserialises 11-bit frames,
// checks parity/stop and queues scancodes behind a KBDready/KBDread handshake.
module ps2_keyboard #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic       KBDread,
    output logic       KBDready,
    output logic [7:0] scancode,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // state | meaning
    // IDLE  | waiting for a falling edge carrying a 0 start bit
    // RECV  | shifting data, parity and stop bits; timeout armed
    // CHECK | one cycle: validate frame, push / drop / flag error
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t                state_q, state_d;
    logic [2:0]            clk_sync_q, data_sync_q;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [9:0]            shift_q, shift_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrptr_q, rdptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  overflow_q, overflow_d;
    logic                  err_q, err_d;
    logic                  fall, bit_in, pop, push, frame_ok, full_after_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2clk};
            data_sync_q <= {data_sync_q[1:0], ps2data};
        end
    end

    assign fall           = (clk_sync_q[2:1] == 2'b10);
    assign bit_in         = data_sync_q[2];
    assign pop            = KBDread && ready_q;
    // shift_q holds {stop, parity, data[7:0]} once all bits are in
    assign frame_ok       = (^shift_q[8:0]) && shift_q[9];
    assign full_after_pop = (count_q == FULL_CNT) && !pop;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        overflow_d = overflow_q;
        err_d      = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmo_d = TW'(TIMEOUT);
                if (fall && !bit_in) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d  = {bit_in, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    tmo_d    = TW'(TIMEOUT);
                    if (bitcnt_q == 4'd10) state_d = CHECK;
                end else if (tmo_q == TW'(1)) begin
                    err_d    = 1'b1;
                    bitcnt_d = 4'd0;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            CHECK: begin
                state_d  = IDLE;
                bitcnt_d = 4'd0;
                if (!frame_ok)          err_d      = 1'b1;
                else if (full_after_pop) overflow_d = 1'b1;
                else                    push       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != '0) && !KBDread;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            tmo_q      <= TW'(TIMEOUT);
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            if (push) wrptr_q <= wrptr_q + 1'b1;
            if (pop)  rdptr_q <= rdptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrptr_q] <= shift_q[7:0];
    end

    assign scancode  = mem[rdptr_q];
    assign KBDready  = ready_q;
    assign overflow  = overflow_q;
    assign frame_err = err_q;

endmodule
